pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the 4-stage core (IF, ID, EX, MEM). Drives the stall and flush inputs of every pipeline register (if_reg, id_reg, ex_reg, mem_reg) and the redirect PC used by if_reg. Resolves bus-wait stalls and load-use bubbles. Sequences exception entry and return through a small FSM that holds EPC and cause.

Parameters:
ADD_WIDTH, 30, word-address width of PC
EXP_CODE_WIDTH, 3, exception cause width; 0 = no exception
EXC_VECTOR, 30'h10, handler word address

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
if_busy_i  in  1  instruction bus not ready this cycle
mem_busy_i  in  1  data bus not ready this cycle
ld_hazard_i  in  1  ID needs result of load currently in EX
mem_en_i  in  1  MEM stage holds a valid instruction
mem_pc_i  in  ADD_WIDTH  PC of instruction in MEM
mem_exp_code_i  in  EXP_CODE_WIDTH  cause raised by instruction in MEM
mem_eret_i  in  1  instruction in MEM is ERET
if_stall_o, id_stall_o, ex_stall_o, mem_stall_o  out  1 each  hold stage register
if_flush_o, id_flush_o, ex_flush_o, mem_flush_o  out  1 each  load NOP/bubble into stage register
new_pc_o  out  ADD_WIDTH  redirect target, valid when if_flush_o=1
epc_o  out  ADD_WIDTH  captured exception PC
exp_code_o  out  EXP_CODE_WIDTH  captured cause
in_handler_o  out  1  FSM in HANDLER
dbl_fault_o  out  1  sticky: exception raised while in HANDLER

Behaviour:
- Reset: FSM=RUN; epc_o=0; exp_code_o=0; dbl_fault_o=0; in_handler_o=0. All stall/flush outputs=0 and new_pc_o=0 while rst_n_i low.
- Stall/flush outputs are combinational from inputs and state (zero latency). epc_o, exp_code_o, FSM and dbl_fault_o update on the clock edge.
- Stall priority, highest first:
  - mem_busy_i: all four stalls=1, all flushes=0, no exception or ERET is accepted.
  - Redirect event (see below): all stalls=0. Flushes apply as defined for the event.
  - ld_hazard_i: if_stall=id_stall=1, ex_flush=1 (bubble), ex/mem_stall=0.
  - if_busy_i alone: if_stall=1, id_flush=1 (bubble so ID does not re-execute the held word).
  - ld_hazard_i and if_busy_i together: use the ld_hazard rule. IF is already stalled.
- Stall and flush are never both asserted for the same stage.
- Exception event: mem_en_i=1, mem_exp_code_i!=0, mem_busy_i=0.
  - Same cycle: all four flushes=1, new_pc_o=EXC_VECTOR.
  - RUN: next edge epc_o<=mem_pc_i, exp_code_o<=mem_exp_code_i, FSM->HANDLER.
  - HANDLER: flush and redirect to vector, epc_o/exp_code_o unchanged, dbl_fault_o<=1 (cleared only by reset).
- ERET event: mem_en_i=1, mem_eret_i=1, mem_exp_code_i=0, mem_busy_i=0, FSM=HANDLER.
  - Same cycle: all flushes=1, new_pc_o=epc_o.
  - Next edge FSM->RUN.
  - ERET while in RUN is ignored (no flush, no redirect).
- If an exception and an ERET arrive in the same cycle, the exception wins.
- mem_en_i=0 suppresses both events regardless of code/eret inputs.
- FSM states: RUN, HANDLER. Transitions only as above. in_handler_o = (FSM==HANDLER).
- Reset mid-handler returns the FSM to RUN and clears epc_o and exp_code_o.

Optional Feature:
PIPE_CTRL_INT_EN: adds ports irq_i (in, 1) and ie_o (out, 1).
- ie_o resets to 1. Cleared on entry to HANDLER. Set on the ERET edge.
- Interrupt event: FSM=RUN, ie_o=1, irq_i=1, mem_en_i=1, mem_busy_i=0, no exception in MEM.
  - Handled as an exception with exp_code_o<={EXP_CODE_WIDTH{1'b1}} and epc_o<=mem_pc_i; the MEM instruction is flushed and re-executed after ERET.
- Without the macro: no ports, no interrupt logic, behaviour as above.

Test Plan:
- Reset with rst_n_i=0 mid-HANDLER -> in_handler_o=0, epc_o=0, exp_code_o=0, all stall/flush=0.
- mem_busy_i=1 together with ld_hazard_i=1 and an exception in MEM (code 3) -> all stalls=1, no flush. When mem_busy_i drops, same cycle all flushes=1, new_pc_o=30'h10. Next cycle epc_o=mem_pc_i, exp_code_o=3.
- ld_hazard_i=1 for 2 cycles -> if/id_stall=1 and ex_flush=1 both cycles, mem_stall=0. if_busy_i=1 alone -> if_stall=1, id_flush=1.
- Exception at mem_pc_i=30'h123, then ERET in MEM -> ERET cycle all flushes=1, new_pc_o=30'h123. Next cycle FSM=RUN.
- Second exception (code 5) while in HANDLER -> redirect to 30'h10, epc_o stays 30'h123, exp_code_o stays first cause, dbl_fault_o=1. ERET in RUN -> no flush.
- PIPE_CTRL_INT_EN: irq_i=1, ie_o=1, mem_pc_i=30'h40 -> flush, exp_code_o=3'b111, epc_o=30'h40, ie_o=0. irq_i held in HANDLER -> no redirect. After ERET, ie_o=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller with exception FSM; stall/flush/new_pc are zero-latency combinational, EPC/cause/FSM update on the edge.
// mem_busy_i freezes the whole pipe and blocks events; optional interrupt entry under `PIPE_CTRL_INT_EN` (ports irq_i, ie_o).
module pipe_ctrl #(
  parameter int ADD_WIDTH      = 30,
  parameter int EXP_CODE_WIDTH = 3,
  parameter logic [ADD_WIDTH-1:0] EXC_VECTOR = 'h10
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      if_busy_i,
  input  logic                      mem_busy_i,
  input  logic                      ld_hazard_i,
  input  logic                      mem_en_i,
  input  logic [ADD_WIDTH-1:0]      mem_pc_i,
  input  logic [EXP_CODE_WIDTH-1:0] mem_exp_code_i,
  input  logic                      mem_eret_i,
`ifdef PIPE_CTRL_INT_EN
  input  logic                      irq_i,
  output logic                      ie_o,
`endif
  output logic                      if_stall_o,
  output logic                      id_stall_o,
  output logic                      ex_stall_o,
  output logic                      mem_stall_o,
  output logic                      if_flush_o,
  output logic                      id_flush_o,
  output logic                      ex_flush_o,
  output logic                      mem_flush_o,
  output logic [ADD_WIDTH-1:0]      new_pc_o,
  output logic [ADD_WIDTH-1:0]      epc_o,
  output logic [EXP_CODE_WIDTH-1:0] exp_code_o,
  output logic                      in_handler_o,
  output logic                      dbl_fault_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_HANDLER = 1'b1} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADD_WIDTH-1:0]      r_epc;
  logic [EXP_CODE_WIDTH-1:0] r_exp_code;
  logic                      r_dbl_fault;
  logic                      w_exp;
  logic                      w_irq;
  logic                      w_take;
  logic                      w_eret;

  assign w_exp  = mem_en_i & (|mem_exp_code_i) & ~mem_busy_i;
  assign w_eret = mem_en_i & mem_eret_i & ~(|mem_exp_code_i) & ~mem_busy_i &
                  (r_state == ST_HANDLER);

`ifdef PIPE_CTRL_INT_EN
  logic r_ie;

  // Interrupt is taken on a clean MEM instruction, which is flushed and replayed after ERET.
  assign w_irq = (r_state == ST_RUN) & r_ie & irq_i & mem_en_i & ~mem_busy_i &
                 ~(|mem_exp_code_i);
  assign ie_o  = r_ie;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ie <= 1'b1;
    end else if ((r_state == ST_RUN) && (w_exp || w_irq)) begin
      r_ie <= 1'b0;
    end else if (w_eret) begin
      r_ie <= 1'b1;
    end
  end
`else
  assign w_irq = 1'b0;
`endif

  assign w_take = w_exp | w_irq;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (w_take) w_state_nxt = ST_HANDLER;
      ST_HANDLER: if (w_eret) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_epc       <= '0;
      r_exp_code  <= '0;
      r_dbl_fault <= 1'b0;
    end else begin
      if ((r_state == ST_RUN) && w_take) begin
        r_epc      <= mem_pc_i;
        r_exp_code <= w_exp ? mem_exp_code_i : {EXP_CODE_WIDTH{1'b1}};
      end
      // Nested fault keeps the original EPC/cause so the first handler can still report it.
      if ((r_state == ST_HANDLER) && w_exp) begin
        r_dbl_fault <= 1'b1;
      end
    end
  end

  always_comb begin
    if_stall_o   = 1'b0;
    id_stall_o   = 1'b0;
    ex_stall_o   = 1'b0;
    mem_stall_o  = 1'b0;
    if_flush_o   = 1'b0;
    id_flush_o   = 1'b0;
    ex_flush_o   = 1'b0;
    mem_flush_o  = 1'b0;
    new_pc_o     = '0;
    in_handler_o = (r_state == ST_HANDLER);
    if (rst_n_i) begin
      if (mem_busy_i) begin
        if_stall_o  = 1'b1;
        id_stall_o  = 1'b1;
        ex_stall_o  = 1'b1;
        mem_stall_o = 1'b1;
      end else if (w_take || w_eret) begin
        if_flush_o  = 1'b1;
        id_flush_o  = 1'b1;
        ex_flush_o  = 1'b1;
        mem_flush_o = 1'b1;
        new_pc_o    = w_take ? EXC_VECTOR : r_epc;
      end else if (ld_hazard_i) begin
        if_stall_o = 1'b1;
        id_stall_o = 1'b1;
        ex_flush_o = 1'b1;
      end else if (if_busy_i) begin
        if_stall_o = 1'b1;
        id_flush_o = 1'b1;
      end
    end
  end

  assign epc_o       = r_epc;
  assign exp_code_o  = r_exp_code;
  assign dbl_fault_o = r_dbl_fault;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl: table of per-cycle stimulus/expectations plus reset and interrupt sequences.
module tb_pipe_ctrl;

  logic        clk_i;
  logic        rst_n_i;
  logic        if_busy_i, mem_busy_i, ld_hazard_i, mem_en_i, mem_eret_i;
  logic [29:0] mem_pc_i;
  logic [2:0]  mem_exp_code_i;
  logic        if_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
  logic        if_flush_o, id_flush_o, ex_flush_o, mem_flush_o;
  logic [29:0] new_pc_o, epc_o;
  logic [2:0]  exp_code_o;
  logic        in_handler_o, dbl_fault_o;
`ifdef PIPE_CTRL_INT_EN
  logic        irq_i, ie_o;
`endif

  logic [3:0] stl, fls;
  assign stl = {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o};
  assign fls = {if_flush_o, id_flush_o, ex_flush_o, mem_flush_o};

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_busy_i(if_busy_i), .mem_busy_i(mem_busy_i), .ld_hazard_i(ld_hazard_i),
    .mem_en_i(mem_en_i), .mem_pc_i(mem_pc_i), .mem_exp_code_i(mem_exp_code_i),
    .mem_eret_i(mem_eret_i),
`ifdef PIPE_CTRL_INT_EN
    .irq_i(irq_i), .ie_o(ie_o),
`endif
    .if_stall_o(if_stall_o), .id_stall_o(id_stall_o), .ex_stall_o(ex_stall_o),
    .mem_stall_o(mem_stall_o), .if_flush_o(if_flush_o), .id_flush_o(id_flush_o),
    .ex_flush_o(ex_flush_o), .mem_flush_o(mem_flush_o), .new_pc_o(new_pc_o),
    .epc_o(epc_o), .exp_code_o(exp_code_o), .in_handler_o(in_handler_o),
    .dbl_fault_o(dbl_fault_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ifb, memb, ld, en, eret;
    logic [29:0] pc;
    logic [2:0]  code;
    logic [3:0]  e_stall, e_flush;
    logic [29:0] e_npc, e_epc;
    logic [2:0]  e_code;
    logic        e_inh, e_dbl;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic ifb, input logic memb, input logic ld, input logic en,
                       input logic eret, input logic [29:0] pc, input logic [2:0] code);
    if_busy_i      = ifb;
    mem_busy_i     = memb;
    ld_hazard_i    = ld;
    mem_en_i       = en;
    mem_eret_i     = eret;
    mem_pc_i       = pc;
    mem_exp_code_i = code;
  endtask

  task automatic check_all(input int row, input logic [3:0] s, input logic [3:0] f,
                           input logic [29:0] npc, input logic [29:0] epc,
                           input logic [2:0] code, input logic inh, input logic dbl);
    check("stall",      row, 32'(stl),          32'(s));
    check("flush",      row, 32'(fls),          32'(f));
    check("new_pc",     row, 32'(new_pc_o),     32'(npc));
    check("epc",        row, 32'(epc_o),        32'(epc));
    check("exp_code",   row, 32'(exp_code_o),   32'(code));
    check("in_handler", row, 32'(in_handler_o), 32'(inh));
    check("dbl_fault",  row, 32'(dbl_fault_o),  32'(dbl));
  endtask

  initial begin
    //            ifb   memb  ld    en    eret  pc        code  stall    flush    npc       epc       code  inh   dbl
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,30'h0,   3'd0, 4'b0000,4'b0000,30'h0,  30'h0,   3'd0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,30'h0,   3'd0, 4'b1100,4'b0010,30'h0,  30'h0,   3'd0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,30'h0,   3'd0, 4'b1100,4'b0010,30'h0,  30'h0,   3'd0,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,30'h0,   3'd0, 4'b1000,4'b0100,30'h0,  30'h0,   3'd0,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,30'h0,   3'd0, 4'b1100,4'b0010,30'h0,  30'h0,   3'd0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,30'h50,  3'd3, 4'b1111,4'b0000,30'h0,  30'h0,   3'd0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,30'h50,  3'd3, 4'b0000,4'b1111,30'h10, 30'h0,   3'd0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,30'h0,   3'd0, 4'b0000,4'b0000,30'h0,  30'h50,  3'd3,1'b1,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,30'h60,  3'd0, 4'b0000,4'b1111,30'h50, 30'h50,  3'd3,1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,30'h0,   3'd0, 4'b0000,4'b0000,30'h0,  30'h50,  3'd3,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,30'h123, 3'd2, 4'b0000,4'b1111,30'h10, 30'h50,  3'd3,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,30'h124, 3'd5, 4'b0000,4'b0000,30'h0,  30'h123, 3'd2,1'b1,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,30'h200, 3'd5, 4'b0000,4'b1111,30'h10, 30'h123, 3'd2,1'b1,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b1,30'h204, 3'd4, 4'b0000,4'b1111,30'h10, 30'h123, 3'd2,1'b1,1'b1};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b1,30'h208, 3'd0, 4'b0000,4'b1111,30'h123,30'h123, 3'd2,1'b1,1'b1};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b1,30'h124, 3'd0, 4'b0000,4'b0000,30'h0,  30'h123, 3'd2,1'b0,1'b1};
    vecs[16] = '{1'b0,1'b1,1'b0,1'b1,1'b0,30'h128, 3'd0, 4'b1111,4'b0000,30'h0,  30'h123, 3'd2,1'b0,1'b1};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b1,1'b0,30'h300, 3'd1, 4'b0000,4'b1111,30'h10, 30'h123, 3'd2,1'b0,1'b1};

`ifdef PIPE_CTRL_INT_EN
    irq_i = 1'b0;
`endif
    // Reset held: even with hazards and an exception present everything must read zero.
    rst_n_i = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 30'h77, 3'd3);
    #12;
    check_all(100, 4'b0000, 4'b0000, 30'h0, 30'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 3'd0);

    for (int r = 0; r < NV; r++) begin
      @(negedge clk_i);
      drive(vecs[r].ifb, vecs[r].memb, vecs[r].ld, vecs[r].en, vecs[r].eret,
            vecs[r].pc, vecs[r].code);
      #1;
      check_all(r, vecs[r].e_stall, vecs[r].e_flush, vecs[r].e_npc, vecs[r].e_epc,
                vecs[r].e_code, vecs[r].e_inh, vecs[r].e_dbl);
    end

    // Last table step entered HANDLER with EPC 0x300 / cause 1; reset asynchronously mid-handler.
    @(negedge clk_i);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 30'h304, 3'd6);
    #1;
    check_all(200, 4'b0000, 4'b1111, 30'h10, 30'h300, 3'd1, 1'b1, 1'b1);
    #1;
    rst_n_i = 1'b0;
    #1;
    check_all(201, 4'b0000, 4'b0000, 30'h0, 30'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 3'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    #1;
    check_all(202, 4'b0000, 4'b0000, 30'h0, 30'h0, 3'd0, 1'b0, 1'b0);

`ifdef PIPE_CTRL_INT_EN
    check("ie_reset", 300, 32'(ie_o), 32'd1);
    @(negedge clk_i);
    irq_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h40, 3'd0);
    #1;
    check_all(301, 4'b0000, 4'b1111, 30'h10, 30'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h44, 3'd0);
    #1;
    check_all(302, 4'b0000, 4'b0000, 30'h0, 30'h40, 3'd7, 1'b1, 1'b0);
    check("ie_cleared", 302, 32'(ie_o), 32'd0);
    @(negedge clk_i);
    irq_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 30'h48, 3'd0);
    #1;
    check_all(303, 4'b0000, 4'b1111, 30'h40, 30'h40, 3'd7, 1'b1, 1'b0);
    @(negedge clk_i);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 3'd0);
    #1;
    check("ie_restored", 304, 32'(ie_o), 32'd1);
    check("in_handler_ret", 304, 32'(in_handler_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
